// File: rtl/cpc_pixel_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : cpc_pixel_decoder_if
// Brief    : Raster-side, VRAM and palette signals of the CPC pixel decoder.
// Revision : 1.0
// ============================================================================
interface cpc_pixel_decoder_if;
  logic [15:0] a_i;
  logic [2:0]  pixel_i;
  logic        border_i;
  logic        de_i;
  logic        hs_i;
  logic        vs_i;
  logic [15:0] vram_a_o;
  logic [7:0]  vram_d_i;
  logic [1:0]  mode_i;
  logic        pal_we_i;
  logic [4:0]  pal_sel_i;
  logic [4:0]  pal_dat_i;
  logic [23:0] color_dat_o;
  logic        de_o;
  logic        hs_o;
  logic        vs_o;

  modport master (
    output a_i, pixel_i, border_i, de_i, hs_i, vs_i, vram_d_i,
           mode_i, pal_we_i, pal_sel_i, pal_dat_i,
    input  vram_a_o, color_dat_o, de_o, hs_o, vs_o
  );

  modport slave (
    input  a_i, pixel_i, border_i, de_i, hs_i, vs_i, vram_d_i,
           mode_i, pal_we_i, pal_sel_i, pal_dat_i,
    output vram_a_o, color_dat_o, de_o, hs_o, vs_o
  );
endinterface
`default_nettype wire

// File: rtl/cpc_pixel_decoder.sv
`default_nettype none
// ============================================================================
// Module   : cpc_pixel_decoder
// Brief    : VRAM fetch, CPC mode 0-3 ink decode, palette and RGB mapping,
//            with sync/DE re-timed to leave alongside the colour.
// Revision : 1.0
// ============================================================================
module cpc_pixel_decoder #(
  parameter int LATENCY = 3
) (
  input wire clk_i,
  input wire reset_i,
  cpc_pixel_decoder_if.slave bus
);

  logic [15:0]        r_vram_a;
  logic [2:0]         r_pix_s1;
  logic               r_bdr_s1;
  logic [3:0]         r_ink_s2;
  logic               r_bdr_s2;
  logic [LATENCY-1:0] r_de_p;
  logic [LATENCY-1:0] r_hs_p;
  logic [LATENCY-1:0] r_vs_p;
  logic [1:0]         r_mode;
  logic               r_hs_prev;
  logic [4:0]         r_pal [0:16];
  logic [23:0]        r_color;

  logic [3:0]         w_ink;
  logic [4:0]         w_hw;
  logic [23:0]        w_rgb;
  logic [7:0]         w_b;

  assign w_b = bus.vram_d_i;

  // Ink bit interleave of the gate array; mode 3 reuses mode 0 selection.
  always_comb begin
    w_ink = 4'd0;
    case (r_mode)
      2'd2: w_ink = {3'b000, w_b[3'd7 - r_pix_s1]};
      2'd1: w_ink = {2'b00, w_b[3'd3 - {1'b0, r_pix_s1[2:1]}],
                            w_b[3'd7 - {1'b0, r_pix_s1[2:1]}]};
      default: begin
        w_ink = r_pix_s1[2] ? {w_b[0], w_b[4], w_b[2], w_b[6]}
                            : {w_b[1], w_b[5], w_b[3], w_b[7]};
        if (r_mode == 2'd3) w_ink[3:2] = 2'b00;
      end
    endcase
  end

  assign w_hw = r_bdr_s2 ? r_pal[16] : r_pal[{1'b0, r_ink_s2}];

  always_comb begin
    w_rgb = 24'h000000;
    case (w_hw)
      5'h00, 5'h01: w_rgb = 24'h808080;
      5'h02, 5'h11: w_rgb = 24'h00FF80;
      5'h03, 5'h09: w_rgb = 24'hFFFF80;
      5'h04, 5'h10: w_rgb = 24'h000080;
      5'h05, 5'h08: w_rgb = 24'hFF0080;
      5'h06:        w_rgb = 24'h008080;
      5'h07:        w_rgb = 24'hFF8080;
      5'h0A:        w_rgb = 24'hFFFF00;
      5'h0B:        w_rgb = 24'hFFFFFF;
      5'h0C:        w_rgb = 24'hFF0000;
      5'h0D:        w_rgb = 24'hFF00FF;
      5'h0E:        w_rgb = 24'hFF8000;
      5'h0F:        w_rgb = 24'hFF80FF;
      5'h12:        w_rgb = 24'h00FF00;
      5'h13:        w_rgb = 24'h00FFFF;
      5'h14:        w_rgb = 24'h000000;
      5'h15:        w_rgb = 24'h0000FF;
      5'h16:        w_rgb = 24'h008000;
      5'h17:        w_rgb = 24'h0080FF;
      5'h18:        w_rgb = 24'h800080;
      5'h19:        w_rgb = 24'h80FF80;
      5'h1A:        w_rgb = 24'h80FF00;
      5'h1B:        w_rgb = 24'h80FFFF;
      5'h1C:        w_rgb = 24'h800000;
      5'h1D:        w_rgb = 24'h8000FF;
      5'h1E:        w_rgb = 24'h808000;
      5'h1F:        w_rgb = 24'h8080FF;
      default:      w_rgb = 24'h000000;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_vram_a  <= 16'h0000;
      r_pix_s1  <= 3'd0;
      r_bdr_s1  <= 1'b0;
      r_ink_s2  <= 4'd0;
      r_bdr_s2  <= 1'b0;
      r_de_p    <= '0;
      r_hs_p    <= '0;
      r_vs_p    <= '0;
      r_mode    <= 2'd1;
      r_hs_prev <= 1'b0;
      r_color   <= 24'h000000;
    end else begin
      r_vram_a  <= bus.a_i;
      r_pix_s1  <= bus.pixel_i;
      r_bdr_s1  <= bus.border_i;
      r_ink_s2  <= w_ink;
      r_bdr_s2  <= r_bdr_s1;
      r_de_p    <= {r_de_p[LATENCY-2:0], bus.de_i};
      r_hs_p    <= {r_hs_p[LATENCY-2:0], bus.hs_i};
      r_vs_p    <= {r_vs_p[LATENCY-2:0], bus.vs_i};
      r_hs_prev <= bus.hs_i;
      // Mode only moves on the HSYNC rising edge, so a line never changes mode mid-way.
      if (bus.hs_i && !r_hs_prev) r_mode <= bus.mode_i;
      r_color   <= r_de_p[LATENCY-2] ? w_rgb : 24'h000000;
    end
  end

  // The S3 read sees the pre-write entry when a write lands on the same edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 17; i++) r_pal[i] <= 5'h14;
    end else if (bus.pal_we_i && (bus.pal_sel_i <= 5'd16)) begin
      r_pal[bus.pal_sel_i] <= bus.pal_dat_i;
    end
  end

  assign bus.vram_a_o    = r_vram_a;
  assign bus.color_dat_o = r_color;
  assign bus.de_o        = r_de_p[LATENCY-1];
  assign bus.hs_o        = r_hs_p[LATENCY-1];
  assign bus.vs_o        = r_vs_p[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_cpc_pixel_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpc_pixel_decoder
// Brief    : Randomised and directed checks of cpc_pixel_decoder against a
//            transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_cpc_pixel_decoder;

  typedef struct {
    logic [15:0] a;
    logic [2:0]  pix;
    logic        bdr;
    logic        de;
    logic        hs;
    logic        vs;
    logic [3:0]  ink;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] vram [0:65535];
  logic [4:0] m_pal [0:16];
  logic [1:0] m_mode;
  logic       m_hs_prev;
  rec_t       q[$];

  // Per hardware colour: R,G,B levels as decimal digits, 0=00 1=80 2=FF.
  int lvl_code [0:31] = '{111, 111, 21, 221, 1, 201, 11, 211,
                          201, 221, 220, 222, 200, 202, 210, 212,
                          1, 21, 20, 22, 0, 2, 10, 12,
                          101, 121, 120, 122, 100, 102, 110, 112};

  cpc_pixel_decoder_if bus();

  cpc_pixel_decoder #(.LATENCY(3)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.vram_d_i = vram[bus.vram_a_o];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] lvl(input int d);
    return (d == 0) ? 8'h00 : ((d == 1) ? 8'h80 : 8'hFF);
  endfunction

  function automatic logic [23:0] ref_rgb(input logic [4:0] hw);
    int code;
    code = lvl_code[hw];
    return {lvl(code / 100), lvl((code / 10) % 10), lvl(code % 10)};
  endfunction

  function automatic logic [3:0] ref_ink(input logic [1:0] mode, input logic [7:0] byt, input int n);
    int b;
    int p;
    int ink;
    b = int'(byt);
    if (mode == 2'd2) begin
      ink = (b >> (7 - n)) & 1;
    end else if (mode == 2'd1) begin
      p   = n / 2;
      ink = ((b >> (7 - p)) & 1) + 2 * ((b >> (3 - p)) & 1);
    end else begin
      p   = n / 4;
      ink = ((b >> (7 - p)) & 1) + 2 * ((b >> (3 - p)) & 1)
          + 4 * ((b >> (5 - p)) & 1) + 8 * ((b >> (1 - p)) & 1);
      if (mode == 2'd3) ink = ink % 4;
    end
    return 4'(ink);
  endfunction

  task automatic model_reset();
    rec_t z;
    z = '{a: 16'h0, pix: 3'd0, bdr: 1'b0, de: 1'b0, hs: 1'b0, vs: 1'b0, ink: 4'd0};
    for (int i = 0; i < 17; i++) m_pal[i] = 5'h14;
    m_mode    = 2'd1;
    m_hs_prev = 1'b0;
    q.delete();
    q.push_back(z);
    q.push_back(z);
  endtask

  // One clock: model the edge from the inputs present at it, then compare.
  task automatic tick();
    rec_t        cur;
    rec_t        old;
    logic [4:0]  hw;
    logic [23:0] exp_c;
    @(posedge clk);
    #1;
    cur = '{a: bus.a_i, pix: bus.pixel_i, bdr: bus.border_i, de: bus.de_i,
            hs: bus.hs_i, vs: bus.vs_i, ink: 4'd0};
    old = q.pop_front();
    q[0].ink = ref_ink(m_mode, vram[q[0].a], int'(q[0].pix));
    q.push_back(cur);
    hw    = old.bdr ? m_pal[16] : m_pal[5'(old.ink)];
    exp_c = old.de ? ref_rgb(hw) : 24'h0;
    check_eq("vram_a", 32'(bus.vram_a_o), 32'(cur.a));
    check_eq("color", 32'(bus.color_dat_o), 32'(exp_c));
    check_eq("sync", 32'({bus.de_o, bus.hs_o, bus.vs_o}), 32'({old.de, old.hs, old.vs}));
    if (bus.hs_i && !m_hs_prev) m_mode = bus.mode_i;
    m_hs_prev = bus.hs_i;
    if (bus.pal_we_i && (bus.pal_sel_i <= 5'd16)) m_pal[bus.pal_sel_i] = bus.pal_dat_i;
  endtask

  task automatic drive(input logic [15:0] a, input int n, input logic bdr, input logic de);
    bus.a_i      = a;
    bus.pixel_i  = 3'(n);
    bus.border_i = bdr;
    bus.de_i     = de;
    tick();
  endtask

  task automatic pal_write(input logic [4:0] sel, input logic [4:0] dat);
    bus.pal_we_i  = 1'b1;
    bus.pal_sel_i = sel;
    bus.pal_dat_i = dat;
    drive(16'h0000, 0, 1'b0, 1'b0);
    bus.pal_we_i  = 1'b0;
  endtask

  task automatic hs_pulse(input logic [1:0] m);
    bus.mode_i = m;
    bus.hs_i   = 1'b1;
    drive(16'h0000, 0, 1'b0, 1'b0);
    bus.hs_i   = 1'b0;
    drive(16'h0000, 0, 1'b0, 1'b0);
  endtask

  task automatic line(input logic [15:0] a);
    for (int n = 0; n < 8; n++) drive(a, n, 1'b0, 1'b1);
    drive(16'h0000, 0, 1'b0, 1'b0);
    drive(16'h0000, 0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.a_i = 16'h0; bus.pixel_i = 3'd0; bus.border_i = 1'b0;
    bus.de_i = 1'b0; bus.hs_i = 1'b0; bus.vs_i = 1'b0; bus.mode_i = 2'd1;
    bus.pal_we_i = 1'b0; bus.pal_sel_i = 5'd0; bus.pal_dat_i = 5'd0;
    for (int i = 0; i < 65536; i++) vram[i] = 8'($urandom);
    vram[16'hC000] = 8'hA5;
    vram[16'hC001] = 8'h88;
    vram[16'hC002] = 8'h22;

    repeat (3) @(negedge clk);
    check_eq("rst_color", 32'(bus.color_dat_o), 32'h0);
    check_eq("rst_de", 32'(bus.de_o), 32'h0);
    check_eq("rst_vram_a", 32'(bus.vram_a_o), 32'h0);
    rst = 1'b0;
    model_reset();

    line(16'hC000);                        // default palette: all black
    hs_pulse(2'd2);
    pal_write(5'd1, 5'h0B);
    line(16'hC000);                        // mode 2 of A5
    pal_write(5'd1, 5'h0C);
    pal_write(5'd3, 5'h0C);
    hs_pulse(2'd0);
    line(16'hC001);                        // mode 0 of 88
    hs_pulse(2'd3);
    line(16'hC002);                        // mode 3 of 22
    pal_write(5'd16, 5'h15);
    for (int n = 0; n < 4; n++) drive(16'hC001, n, 1'b1, 1'b1);
    for (int n = 0; n < 4; n++) drive(16'hC000, n, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) drive(16'hC000, n, 1'b0, 1'b0);
    pal_write(5'd20, 5'h0B);               // out-of-range select

    hs_pulse(2'd2);
    bus.mode_i = 2'd0;                     // no HSYNC rise: stays mode 2
    line(16'hC000);
    hs_pulse(2'd0);
    line(16'hC000);

    hs_pulse(2'd2);
    pal_write(5'd1, 5'h0B);
    drive(16'hC000, 0, 1'b0, 1'b1);        // ink 1
    drive(16'hC000, 1, 1'b0, 1'b1);
    bus.pal_we_i = 1'b1; bus.pal_sel_i = 5'd1; bus.pal_dat_i = 5'h0C;
    drive(16'hC000, 2, 1'b0, 1'b1);        // write lands as ink 1 is read
    bus.pal_we_i = 1'b0;
    line(16'hC000);

    drive(16'hC000, 0, 1'b0, 1'b1);
    drive(16'hC000, 2, 1'b0, 1'b1);
    #3 rst = 1'b1;
    #1;
    check_eq("midrst_color", 32'(bus.color_dat_o), 32'h0);
    check_eq("midrst_de", 32'(bus.de_o), 32'h0);
    check_eq("midrst_vram_a", 32'(bus.vram_a_o), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bus.mode_i = 2'd1;
    line(16'hC000);
    line(16'hC001);

    for (int i = 0; i < 1500; i++) begin
      bus.a_i       = 16'hC000 + 16'($urandom_range(0, 15));
      bus.pixel_i   = 3'($urandom);
      bus.border_i  = ($urandom_range(0, 7) == 0);
      bus.de_i      = ($urandom_range(0, 3) != 0);
      bus.hs_i      = ($urandom_range(0, 15) == 0);
      bus.vs_i      = ($urandom_range(0, 31) == 0);
      bus.mode_i    = 2'($urandom);
      bus.pal_we_i  = ($urandom_range(0, 7) == 0);
      bus.pal_sel_i = 5'($urandom);
      bus.pal_dat_i = 5'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
